nes_bus_mem: RTL

- Parametrised behavioural/synthesisable memory model for the 2A03 CPU bus. Successor to the flat 64 KiB single-cycle bench memory.
- Decodes three regions: mirrored internal RAM, read-only PRG ROM, and unmapped space.
- Adds configurable read latency, NES-style open-bus behaviour, and a sticky ROM-write error report.
- Sits between cpu_2a03 and the testbench, or an FPGA top, driven from the CPU address/data/rw lines.

---
 rtl/nes_mem_pkg.sv | 37 +++
 rtl/mem_read_pipe.sv | 34 +++
 rtl/nes_bus_mem.sv | 119 +++++++++++
 3 files changed

// File: rtl/nes_mem_pkg.sv
// Shared types and address decode for the 2A03 CPU-bus memory model.
package nes_mem_pkg;

    typedef enum logic [1:0] {
        REG_RAM,
        REG_ROM,
        REG_UNMAPPED
    } region_e;

    localparam int NES_RAM_BYTES = 2048;
    localparam int NES_RAM_END   = 'h2000;
    localparam int NES_ROM_BASE  = 'h8000;

    typedef struct packed {
        region_e     region;
        logic [31:0] index;
    } decode_t;

    // RAM is mirrored by masking, so ram_bytes must be a power of two.
    function automatic decode_t nes_decode(input logic [31:0] addr,
                                           input logic [31:0] ram_bytes,
                                           input logic [31:0] ram_end,
                                           input logic [31:0] rom_base);
        decode_t d;
        d.region = REG_UNMAPPED;
        d.index  = '0;
        if (addr < ram_end) begin
            d.region = REG_RAM;
            d.index  = addr & (ram_bytes - 32'd1);
        end else if (addr >= rom_base) begin
            d.region = REG_ROM;
            d.index  = addr - rom_base;
        end
        return d;
    endfunction

endpackage

// File: rtl/mem_read_pipe.sv
// Fixed-depth {valid, data} delay line feeding the memory read port.
module mem_read_pipe #(
    parameter int DEPTH = 1,
    parameter int WIDTH = 8
) (
    input  logic             clock,
    input  logic             nreset,
    input  logic             in_valid,
    input  logic [WIDTH-1:0] in_data,
    output logic             out_valid,
    output logic [WIDTH-1:0] out_data
);

    logic [DEPTH-1:0] valid_q;
    logic [WIDTH-1:0] data_q [DEPTH];

    always_ff @(posedge clock or negedge nreset) begin
        if (!nreset) begin
            valid_q <= '0;
            for (int i = 0; i < DEPTH; i++) data_q[i] <= '0;
        end else begin
            valid_q[0] <= in_valid;
            data_q[0]  <= in_data;
            for (int i = 1; i < DEPTH; i++) begin
                valid_q[i] <= valid_q[i-1];
                data_q[i]  <= data_q[i-1];
            end
        end
    end

    assign out_valid = valid_q[DEPTH-1];
    assign out_data  = data_q[DEPTH-1];

endmodule

// File: rtl/nes_bus_mem.sv
// 2A03 bus memory: mirrored RAM, read-only PRG ROM, unmapped space, delayed reads.
// Define NES_BUS_MEM_OPEN_BUS_EN to make unmapped reads return the open-bus latch.
module nes_bus_mem
    import nes_mem_pkg::*;
#(
    parameter int ADDR_W       = 16,
    parameter int DATA_W       = 8,
    parameter int RAM_BYTES    = NES_RAM_BYTES,
    parameter int RAM_END      = NES_RAM_END,
    parameter int ROM_BASE     = NES_ROM_BASE,
    parameter int READ_LATENCY = 1
) (
    input  logic              clock,
    input  logic              nreset,
    input  logic [ADDR_W-1:0] addr,
    input  logic              rw,
    input  logic [DATA_W-1:0] data_in,
    output logic [DATA_W-1:0] data_out,
    output logic              data_valid,
    output logic              rom_wr_err,
    output logic [ADDR_W-1:0] rom_wr_addr
);

    localparam int RAM_IDX_W = $clog2(RAM_BYTES);
    localparam int ROM_BYTES = (1 << ADDR_W) - ROM_BASE;
    localparam int ROM_IDX_W = $clog2(ROM_BYTES);

    if ((RAM_BYTES < 1) || ((RAM_BYTES & (RAM_BYTES - 1)) != 0)) begin : g_bad_ram_bytes
        $error("nes_bus_mem: RAM_BYTES must be a power of 2");
    end
    if ((READ_LATENCY < 1) || (READ_LATENCY > 4)) begin : g_bad_latency
        $error("nes_bus_mem: READ_LATENCY must be in 1..4");
    end
    if (RAM_END > ROM_BASE) begin : g_bad_windows
        $error("nes_bus_mem: RAM_END must not exceed ROM_BASE");
    end

    logic [DATA_W-1:0]    ram [0:RAM_BYTES-1];
    logic [DATA_W-1:0]    rom [0:ROM_BYTES-1];
    decode_t              dec;
    logic [RAM_IDX_W-1:0] ram_idx;
    logic [ROM_IDX_W-1:0] rom_idx;
    logic [DATA_W-1:0]    rd_data;
    logic                 pipe_valid;
    logic [DATA_W-1:0]    pipe_data;
    logic                 unused_idx_bits;

    assign dec             = nes_decode(32'(addr), 32'(RAM_BYTES), 32'(RAM_END), 32'(ROM_BASE));
    assign ram_idx         = dec.index[RAM_IDX_W-1:0];
    assign rom_idx         = dec.index[ROM_IDX_W-1:0];
    assign unused_idx_bits = ^dec.index;

`ifdef NES_BUS_MEM_OPEN_BUS_EN
    logic [DATA_W-1:0] open_bus;

    // A read emerging on the bus is the newest bus value, so it overrides a same-edge write.
    always_ff @(posedge clock or negedge nreset) begin
        if (!nreset) begin
            open_bus <= '0;
        end else begin
            if (!rw) open_bus <= data_in;
            if (pipe_valid) open_bus <= pipe_data;
        end
    end
`endif

    always_comb begin
        rd_data = '0;
        case (dec.region)
            REG_RAM: rd_data = ram[ram_idx];
            REG_ROM: rd_data = rom[rom_idx];
            default: begin
`ifdef NES_BUS_MEM_OPEN_BUS_EN
                rd_data = open_bus;
`else
                rd_data = '0;
`endif
            end
        endcase
    end

    // Storage is left out of reset so preloaded images survive it.
    always_ff @(posedge clock) begin
        if (!rw && (dec.region == REG_RAM)) ram[ram_idx] <= data_in;
    end

    always_ff @(posedge clock or negedge nreset) begin
        if (!nreset) begin
            rom_wr_err  <= 1'b0;
            rom_wr_addr <= '0;
        end else if (!rw && (dec.region == REG_ROM)) begin
            rom_wr_err <= 1'b1;
            if (!rom_wr_err) rom_wr_addr <= addr;
        end
    end

    mem_read_pipe #(
        .DEPTH (READ_LATENCY),
        .WIDTH (DATA_W)
    ) u_pipe (
        .clock     (clock),
        .nreset    (nreset),
        .in_valid  (rw),
        .in_data   (rw ? rd_data : '0),
        .out_valid (pipe_valid),
        .out_data  (pipe_data)
    );

    always_ff @(posedge clock or negedge nreset) begin
        if (!nreset) begin
            data_out   <= '0;
            data_valid <= 1'b0;
        end else begin
            data_out   <= pipe_data;
            data_valid <= pipe_valid;
        end
    end

endmodule
